// File: rtl/seg7_scan_driver_pkg.sv
// seg7_scan_driver_pkg: shared 7-segment display constants (logical, active-high, a..g)
package seg7_scan_driver_pkg;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_DARK = 7'b0000000;
  localparam seg_t [15:0] GLYPHS = {
    7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
    7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
    7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
    7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
  };
endpackage

// File: rtl/hex_glyph_rom.sv
// hex_glyph_rom: nibble to logical 7-segment glyph
module hex_glyph_rom
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] i_nib,
  output seg_t       o_glyph
);
  assign o_glyph = GLYPHS[i_nib];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: round-robin multiplexed 7-segment driver with guard interval and leading-zero blanking
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int CLK_DIV          = 50000,
  parameter int GUARD            = 16,
  parameter int SEG_ACTIVE_LOW   = 0,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lzb_en,
  output logic [6:0]              segments,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en
);
  localparam int   PW      = $clog2(CLK_DIV);
  localparam int   IW      = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic SEG_INV = SEG_ACTIVE_LOW != 0;
  localparam logic DIG_INV = DIGIT_ACTIVE_LOW != 0;
  logic [PW-1:0]           r_pcnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_sh_data;
  logic [NUM_DIGITS-1:0]   r_sh_dp, r_sh_blank, r_dig, w_lz, w_dig;
  seg_t                    r_seg, w_glyph, w_seg;
  logic                    r_dp, w_dp, w_blank, w_zero_hi, w_wrap;
  assign w_wrap = r_pcnt == PW'(CLK_DIV - 1);
  hex_glyph_rom u_rom (.i_nib(r_sh_data[4*r_idx +: 4]), .o_glyph(w_glyph));
  // w_zero_hi accumulates "all nibbles from the top down to i are zero"
  always_comb begin
    w_zero_hi = 1'b1;
    w_lz = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_hi = w_zero_hi & (r_sh_data[4*i +: 4] == 4'd0);
      w_lz[i] = lzb_en & (i != 0) & w_zero_hi;
    end
  end
  assign w_blank = r_sh_blank[r_idx];
  assign w_seg   = (w_blank | w_lz[r_idx]) ? SEG_DARK : w_glyph;
  assign w_dp    = r_sh_dp[r_idx] & ~w_blank;
  assign w_dig   = (r_pcnt < PW'(GUARD)) ? '0 : NUM_DIGITS'(1) << r_idx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt     <= '0;
      r_idx      <= '0;
      r_sh_data  <= '0;
      r_sh_dp    <= '0;
      r_sh_blank <= '0;
      r_seg      <= {7{SEG_INV}};
      r_dp       <= SEG_INV;
      r_dig      <= {NUM_DIGITS{DIG_INV}};
    end else begin
      r_pcnt <= w_wrap ? '0 : r_pcnt + 1'b1;
      if (w_wrap) r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      if (load) begin
        r_sh_data  <= data_in;
        r_sh_dp    <= dp_in;
        r_sh_blank <= blank_in;
      end
      r_seg <= w_seg ^ {7{SEG_INV}};
      r_dp  <= w_dp ^ SEG_INV;
      r_dig <= w_dig ^ {NUM_DIGITS{DIG_INV}};
    end
  end
  assign segments = r_seg;
  assign dp_out   = r_dp;
  assign digit_en = r_dig;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench with a slot-arithmetic reference model
module tb_seg7_scan_driver;
  localparam int N = 4, CD = 8, G = 2;
  logic        clk = 0, rst_n = 0, load = 0, lzb_en = 0;
  logic [15:0] data_in = 0;
  logic [3:0]  dp_in = 0, blank_in = 0, digit_en;
  logic [6:0]  segments;
  logic        dp_out;
  int vectors = 0, miscompares = 0;
  typedef struct { logic [6:0] seg; logic dp; logic [3:0] dig; } exp_t;
  exp_t q[$];
  bit [6:0] gl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  int          t = 0;
  logic [15:0] m_data = 0;
  logic [3:0]  m_dp = 0, m_blank = 0;

  seg7_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(CD), .GUARD(G), .SEG_ACTIVE_LOW(0), .DIGIT_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
    .lzb_en(lzb_en), .segments(segments), .dp_out(dp_out), .digit_en(digit_en));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: slot = t / CD, position in slot = t % CD; output appears one edge later
  always @(posedge clk) begin
    exp_t e;
    int p, i;
    logic lz;
    if (!rst_n) begin
      t = 0; m_data = 0; m_dp = 0; m_blank = 0;
      e.seg = 0; e.dp = 0; e.dig = 0;
    end else begin
      p = t % CD;
      i = (t / CD) % N;
      lz = lzb_en && i != 0 && ((m_data >> (4 * i)) == 16'd0);
      e.seg = (m_blank[i] || lz) ? 7'd0 : gl[(m_data >> (4 * i)) & 16'hF];
      e.dp = m_dp[i] && !m_blank[i];
      e.dig = (p < G) ? 4'd0 : 4'(1 << i);
      t++;
      if (load) begin m_data = data_in; m_dp = dp_in; m_blank = blank_in; end
    end
    q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_segments", 16'(segments), 16'(e.seg));
      chk("sb_dp_out", 16'(dp_out), 16'(e.dp));
      chk("sb_digit_en", 16'(digit_en), 16'(e.dig));
    end
  end

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    data_in = d; dp_in = p; blank_in = b; load = 1;
    @(negedge clk);
    load = 0;
    @(negedge clk);
  endtask

  task automatic show(input int d, input logic [6:0] es, input logic edp);
    int n = 0;
    while (digit_en !== 4'(1 << d) && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) begin
      vectors++; miscompares++;
      $display("FAIL wait_d%0d: timed out, digit_en=%b required %b", d, digit_en, 4'(1 << d));
    end else begin
      chk($sformatf("d%0d_segments", d), 16'(segments), 16'(es));
      chk($sformatf("d%0d_dp", d), 16'(dp_out), 16'(edp));
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_segments", 16'(segments), 16'h0);
    chk("rst_digit_en", 16'(digit_en), 16'h0);
    rst_n = 1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 2 || c == 3 || c == 10 || c == 11)
        chk($sformatf("cycle%0d_digit_en", c), 16'(digit_en), (c == 3) ? 16'h1 : (c == 11) ? 16'h2 : 16'h0);
    end
    do_load(16'h12AF, 4'b0100, 4'b0000);
    show(0, 7'b1000111, 0); show(1, 7'b1110111, 0); show(2, 7'b1101101, 1); show(3, 7'b0110000, 0);
    lzb_en = 1;
    do_load(16'h0050, 4'b0000, 4'b0000);
    show(0, 7'b1111110, 0); show(1, 7'b1011011, 0); show(2, 7'b0000000, 0); show(3, 7'b0000000, 0);
    do_load(16'h0000, 4'b0000, 4'b0000);
    show(0, 7'b1111110, 0); show(1, 7'b0000000, 0); show(2, 7'b0000000, 0); show(3, 7'b0000000, 0);
    lzb_en = 0;
    do_load(16'h1234, 4'b0010, 4'b0010);
    show(1, 7'b0000000, 0); show(0, 7'b0110011, 0);
    n = 0;
    while (digit_en !== 4'b0100 && n < 64) begin @(negedge clk); n++; end
    chk("pre_reset_d2", 16'(digit_en), 16'h4);
    #2 rst_n = 0;
    #1;
    chk("async_segments", 16'(segments), 16'h0);
    chk("async_dp", 16'(dp_out), 16'h0);
    chk("async_digit_en", 16'(digit_en), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    n = 0;
    while (digit_en === 4'b0000 && n < 16) begin @(negedge clk); n++; end
    chk("restart_digit_en", 16'(digit_en), 16'h1);
    chk("restart_cycle", 16'(n), 16'd3);
    chk("restart_segments", 16'(segments), 16'(7'b1111110));
    n = 0;
    while (t % (CD * N) != CD * N - 1 && n < 64) begin @(negedge clk); n++; end
    data_in = 16'h3A7C; dp_in = 0; blank_in = 0; load = 1;
    @(negedge clk);
    load = 0;
    show(0, 7'b1001110, 0);
    for (int k = 0; k < 40; k++) begin data_in = 16'($urandom); @(negedge clk); end
    show(0, 7'b1001110, 0); show(3, 7'b1111001, 0);
    for (int k = 0; k < 1500; k++) begin
      logic [15:0] mask;
      mask = 16'hFFFF >> (4 * $urandom_range(4));
      data_in = 16'($urandom) & mask;
      dp_in = 4'($urandom);
      blank_in = ($urandom_range(3) == 0) ? 4'($urandom) : 4'd0;
      lzb_en = 1'($urandom_range(1));
      load = ($urandom_range(7) == 0);
      @(negedge clk);
    end
    load = 0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for an N-digit common-electrode 7-segment display. It captures a packed hex word plus per-digit decimal-point and blank masks, then scans the digits round-robin at a programmable rate. Each digit slot starts with an anti-ghosting guard interval, and leading-zero blanking is optional. It sits between the datapath result registers and the board display pins.

## Interface
- NUM_DIGITS, 4: digits scanned; must be ≥ 1.
- CLK_DIV, 50000: clock cycles per digit slot; must be ≥ 2.
- GUARD, 16: cycles at the start of each slot with all digits disabled; must be < CLK_DIV.
- SEG_ACTIVE_LOW, 0: 1 inverts `segments` and `dp_out` at the pins.
- DIGIT_ACTIVE_LOW, 1: 1 inverts `digit_en` at the pins.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  capture strobe for `data_in`, `dp_in` and `blank_in`.
- data_in  in  4*NUM_DIGITS  hex nibbles; digit i is bits [4i+3:4i]; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal point per digit.
- blank_in  in  NUM_DIGITS  force digit dark (segments and dp).
- lzb_en  in  1  leading-zero blanking enable; used live, not captured.
- segments  out  7  [6]=a … [0]=g.
- dp_out  out  1  decimal point of the active digit.
- digit_en  out  NUM_DIGITS  one-hot digit select, or all inactive.

## Operation
- Shadow registers `sh_data`, `sh_dp` and `sh_blank` load when `load`=1 at a clock edge. When `load`=0 they hold.
- Prescaler `pcnt` has width clog2(CLK_DIV). It counts 0 … CLK_DIV-1 and wraps to 0.
- Digit index `idx` has width max(1, clog2(NUM_DIGITS)).
  - It increments on the edge where `pcnt`=CLK_DIV-1.
  - It wraps from NUM_DIGITS-1 to 0.
  - With NUM_DIGITS=1 it stays at 0.
- Logical glyphs, active-high, a..g:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - dark=0000000
- Leading-zero blank (lz) for digit i is true when all of the following hold:
  - `lzb_en`=1
  - i ≠ 0
  - every captured nibble j ≥ i is 0
- Digit i is dark when `sh_blank[i]` is set or lz is true.
  - `sh_blank` dark forces dp off.
  - lz dark keeps dp = `sh_dp[i]`.
- Guard interval: while `pcnt` < GUARD, `digit_en` is all inactive. `segments` still show the glyph for the current `idx`.
- Physical polarity inversions are applied last.

## Timing
- All outputs are registered. They reflect the state (`idx`, `pcnt`, shadow) of the previous cycle, so output latency is 1 cycle.
- A `load` sampled at edge N changes the outputs at edge N+1, provided the current slot is past its guard interval.
- `idx` changes at edge K. The new digit is lit from edge K+GUARD+1 and stays lit through edge K+CLK_DIV.
- Reset (asynchronous assert; release is synchronised by the caller):
  - `pcnt`=0, `idx`=0, all shadows 0.
  - `segments` and `dp_out` at inactive level (all 0, or all 1 if SEG_ACTIVE_LOW).
  - `digit_en` all inactive.
- Reset asserted mid-slot forces these values immediately, without waiting for a clock.
- After reset, the first lit digit is digit 0, at cycle GUARD+1.
- Changes on `data_in` while `load`=0 have no effect.
- Changes on `lzb_en` take effect 1 cycle later.
- `load` coinciding with an index wrap: the capture and the advance both apply. The new digit shows the new data.

## Structure
- The glyph constants and the dark code belong in a shared include file of display constants. Other display blocks reuse them.
- One sub-module, `hex_glyph_rom`: combinational nibble → 7-bit logical glyph. A single instance is muxed by `idx`.
- The top level holds the prescaler, index counter, shadows, lz logic and output registers.

## Test plan
Bench setup: NUM_DIGITS=4, CLK_DIV=8, GUARD=2, SEG_ACTIVE_LOW=0, DIGIT_ACTIVE_LOW=0.
- Reset then idle:
  - `segments`=0000000 and `digit_en`=0000 while `rst_n`=0.
  - After release, `digit_en`=0001 first at cycle 3, then 0010 at cycle 11.
- Load 0x12AF with `dp_in`=0100 → one scan shows the glyphs below.
  - d0: `segments`=1000111 (F), `dp_out`=0.
  - d1: `segments`=1110111 (A), `dp_out`=0.
  - d2: `segments`=1101101 (2), `dp_out`=1.
  - d3: `segments`=0110000 (1), `dp_out`=0.
- Load 0x0050 with `lzb_en`=1 → d3 and d2 dark; d1=1011011 (5); d0=1111110 (0). Load 0x0000 → only d0 lit, showing 0.
- `blank_in`=0010 with `dp_in`=0010 → during d1's slot, `segments`=0000000 and `dp_out`=0.
- Assert `rst_n` low mid-slot while d2 is lit → outputs inactive in the same cycle, without a clock edge. After release, scanning restarts at d0.
- Pulse `load` on the wrap cycle from d3 to d0 → d0 shows the newly loaded nibble. With `load` held low, toggling `data_in` leaves the outputs unchanged.
